// File: rtl/irq_controller.sv
// External interrupt controller: latches peripheral requests, masks them, and hands the
// lowest enabled ID to the core through a REQ/claim/COMPLETE handshake. Macro IRQC_LEVEL_EN selects level-sensitive sources.
module irq_controller #(
  parameter int NUM_SRC = 8
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic [NUM_SRC-1:0] irq_src_i,
  input  logic               ack_i,
  output logic               meip_o,
  input  logic [1:0]         addr_i,
  input  logic [31:0]        wdata_i,
  input  logic               wen_i,
  input  logic               ren_i,
  output logic [31:0]        rdata_o
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_BUSY} state_t;

  localparam logic [1:0] A_PENDING  = 2'd0;
  localparam logic [1:0] A_ENABLE   = 2'd1;
  localparam logic [1:0] A_CLAIM    = 2'd2;
  localparam logic [1:0] A_COMPLETE = 2'd3;

  state_t             state_q, state_d;
  logic [NUM_SRC-1:0] pending_q, enable_q, active, ack_mask;
  logic [4:0]         sel_id, claim_q, claim_d;
  logic               claim_take, complete_hit;

  assign active = pending_q & enable_q;

  // Lowest index wins, so scan downward and let the last hit stand.
  always_comb begin
    sel_id   = '0;
    ack_mask = '0;
    for (int k = NUM_SRC - 1; k >= 0; k--) begin
      if (active[k]) sel_id = 5'(k + 1);
    end
    for (int k = 0; k < NUM_SRC; k++) begin
      ack_mask[k] = claim_take && (sel_id == 5'(k + 1));
    end
  end

  assign claim_take   = (state_q == S_REQ) && ack_i && (sel_id != 5'd0);
  assign complete_hit = (state_q == S_BUSY) && wen_i && (addr_i == A_COMPLETE)
                        && (wdata_i[4:0] == claim_q);

`ifdef IRQC_LEVEL_EN
  always_ff @(posedge clk_i) begin
    if (reset_i) pending_q <= '0;
    else         pending_q <= irq_src_i;
  end
`else
  logic [NUM_SRC-1:0] src_q, w1c_mask;

  assign w1c_mask = (wen_i && addr_i == A_PENDING) ? wdata_i[NUM_SRC-1:0] : '0;

  // A fresh edge is OR-ed in after the clears so a coincident set always survives.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      src_q     <= '0;
      pending_q <= '0;
    end else begin
      src_q     <= irq_src_i;
      pending_q <= (pending_q & ~(w1c_mask | ack_mask)) | (irq_src_i & ~src_q);
    end
  end
`endif

  always_comb begin
    state_d = state_q;
    claim_d = claim_q;
    case (state_q)
      S_IDLE: if (sel_id != 5'd0) state_d = S_REQ;
      S_REQ: begin
        if (claim_take) begin
          claim_d = sel_id;
          state_d = S_BUSY;
        end else if (sel_id == 5'd0) begin
          state_d = S_IDLE;
        end
      end
      S_BUSY: begin
        if (complete_hit) begin
          claim_d = '0;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q  <= S_IDLE;
      claim_q  <= '0;
      enable_q <= '0;
    end else begin
      state_q <= state_d;
      claim_q <= claim_d;
      if (wen_i && addr_i == A_ENABLE) enable_q <= wdata_i[NUM_SRC-1:0];
    end
  end

  assign meip_o = (state_q == S_REQ);

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      rdata_o <= '0;
    end else if (ren_i) begin
      case (addr_i)
        A_PENDING: rdata_o <= {{(32 - NUM_SRC){1'b0}}, pending_q};
        A_ENABLE:  rdata_o <= {{(32 - NUM_SRC){1'b0}}, enable_q};
        A_CLAIM:   rdata_o <= {27'd0, claim_q};
        default:   rdata_o <= '0;
      endcase
    end
  end

endmodule

// File: tb/tb_irq_controller.sv
// Directed bench for irq_controller (edge-triggered build): walks the claim/complete
// handshake, masking, priority, set-wins and reset-abort cases against hand-computed values.
module tb_irq_controller;

  localparam int NUM_SRC = 8;

  logic               clk_i = 1'b0;
  logic               reset_i;
  logic [NUM_SRC-1:0] irq_src_i;
  logic               ack_i;
  logic               meip_o;
  logic [1:0]         addr_i;
  logic [31:0]        wdata_i;
  logic               wen_i;
  logic               ren_i;
  logic [31:0]        rdata_o;

  int n_checks = 0;
  int n_errors = 0;
  logic [31:0] rd;

  irq_controller #(.NUM_SRC(NUM_SRC)) dut (
    .clk_i(clk_i), .reset_i(reset_i), .irq_src_i(irq_src_i), .ack_i(ack_i),
    .meip_o(meip_o), .addr_i(addr_i), .wdata_i(wdata_i), .wen_i(wen_i),
    .ren_i(ren_i), .rdata_o(rdata_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Inputs change 1 time unit after a rising edge; outputs are read at that same point.
  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic reg_wr(input logic [1:0] a, input logic [31:0] d);
    addr_i = a; wdata_i = d; wen_i = 1'b1;
    tick();
    wen_i = 1'b0; wdata_i = '0;
  endtask

  task automatic reg_rd(input logic [1:0] a, output logic [31:0] d);
    addr_i = a; ren_i = 1'b1;
    tick();
    ren_i = 1'b0;
    d = rdata_o;
  endtask

  task automatic pulse_src(input logic [NUM_SRC-1:0] s);
    irq_src_i = s;
    tick();
    irq_src_i = '0;
  endtask

  task automatic pulse_ack();
    ack_i = 1'b1;
    tick();
    ack_i = 1'b0;
  endtask

  initial begin
    reset_i = 1'b1; irq_src_i = '0; ack_i = 1'b0; addr_i = '0;
    wdata_i = '0; wen_i = 1'b0; ren_i = 1'b0;
    tick(); tick();
    check("reset_meip", {31'd0, meip_o}, 32'd0);
    check("reset_rdata", rdata_o, 32'd0);
    reset_i = 1'b0;
    tick();

    // Basic claim of ID 3
    reg_wr(2'd1, 32'h05);
    pulse_src(8'h04);
    check("t1_meip_n1", {31'd0, meip_o}, 32'd0);
    tick();
    check("t1_meip_n2", {31'd0, meip_o}, 32'd1);
    pulse_ack();
    check("t1_meip_busy", {31'd0, meip_o}, 32'd0);
    reg_rd(2'd2, rd); check("t1_claim", rd, 32'd3);
    reg_rd(2'd0, rd); check("t1_pending", rd, 32'h00);
    reg_wr(2'd3, 32'd3);
    check("t1_meip_done", {31'd0, meip_o}, 32'd0);
    reg_rd(2'd2, rd); check("t1_claim_idle", rd, 32'd0);
    tick();
    check("t1_meip_stay", {31'd0, meip_o}, 32'd0);

    // Priority: sources 5 and 1 together
    reg_wr(2'd1, 32'hFF);
    reg_rd(2'd1, rd); check("t2_enable_rd", rd, 32'hFF);
    pulse_src(8'h22);
    tick();
    check("t2_meip", {31'd0, meip_o}, 32'd1);
    pulse_ack();
    reg_rd(2'd2, rd); check("t2_claim_a", rd, 32'd2);
    reg_wr(2'd3, 32'd2);
    check("t2_meip_idle", {31'd0, meip_o}, 32'd0);
    tick();
    check("t2_meip_rereq", {31'd0, meip_o}, 32'd1);
    pulse_ack();
    reg_rd(2'd2, rd); check("t2_claim_b", rd, 32'd6);
    reg_wr(2'd3, 32'd6);
    reg_rd(2'd0, rd); check("t2_pending_empty", rd, 32'h00);

    // Masking in REQ withdraws the request
    reg_wr(2'd1, 32'h01);
    pulse_src(8'h01);
    tick();
    check("t3_meip_req", {31'd0, meip_o}, 32'd1);
    reg_wr(2'd1, 32'h00);
    tick();
    check("t3_meip_drop", {31'd0, meip_o}, 32'd0);
    reg_rd(2'd0, rd); check("t3_pending", rd, 32'h01);
    pulse_ack();
    reg_rd(2'd2, rd); check("t3_claim_ignored", rd, 32'd0);
    reg_wr(2'd0, 32'h01);
    reg_rd(2'd0, rd); check("t3_w1c", rd, 32'h00);

    // Set wins against ack clear; mismatched COMPLETE ignored
    reg_wr(2'd1, 32'hFF);
    pulse_src(8'h08);
    tick();
    check("t4_meip_req", {31'd0, meip_o}, 32'd1);
    irq_src_i = 8'h08; ack_i = 1'b1;
    tick();
    irq_src_i = '0; ack_i = 1'b0;
    reg_rd(2'd0, rd); check("t4_pending_kept", rd, 32'h08);
    reg_rd(2'd2, rd); check("t4_claim", rd, 32'd4);
    reg_wr(2'd3, 32'd7);
    tick();
    check("t4_busy_meip", {31'd0, meip_o}, 32'd0);
    reg_rd(2'd2, rd); check("t4_claim_after_bad", rd, 32'd4);
    reg_wr(2'd3, 32'd4);
    tick();
    check("t4_reserve_meip", {31'd0, meip_o}, 32'd1);
    pulse_ack();
    reg_rd(2'd2, rd); check("t4_claim_again", rd, 32'd4);
    reg_rd(2'd0, rd); check("t4_pending_clr", rd, 32'h00);

    // Reset in BUSY with source 0 held high
    irq_src_i = 8'h01;
    reset_i = 1'b1;
    tick();
    check("t5_rst_meip", {31'd0, meip_o}, 32'd0);
    check("t5_rst_rdata", rdata_o, 32'd0);
    tick();
    reset_i = 1'b0;
    tick();
    reg_rd(2'd0, rd); check("t5_pending", rd, 32'h01);
    reg_rd(2'd1, rd); check("t5_enable", rd, 32'h00);
    reg_rd(2'd2, rd); check("t5_claim", rd, 32'd0);
    check("t5_meip", {31'd0, meip_o}, 32'd0);
    irq_src_i = '0;

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/irq_controller.md
# irq_controller

External interrupt controller feeding the core's machine-external-interrupt line. Collects up to `NUM_SRC` peripheral interrupt requests, latches them as pending, masks them with a software-writable enable register, and drives `meip_o` into the CSR unit's `meip_i`. It consumes the CSR unit's one-cycle `ack_o` pulse as the claim strobe, and is serviced by the trap handler over a small word-addressed register port on the data bus.

## Interface
- `NUM_SRC`, 8: number of interrupt sources, 1..31. Source index k has ID k+1; ID 0 means "none".
- `clk_i`  in  1  clock; all logic on rising edge.
- `reset_i`  in  1  synchronous, active-high reset.
- `irq_src_i`  in  NUM_SRC  peripheral requests, synchronous to `clk_i`.
- `ack_i`  in  1  claim strobe from CSR unit `ack_o`, one-cycle pulse.
- `meip_o`  out  1  external interrupt request to CSR unit `meip_i`.
- `addr_i`  in  2  word offset: 0 PENDING, 1 ENABLE, 2 CLAIM, 3 COMPLETE.
- `wdata_i`  in  32  write data.
- `wen_i`  in  1  active-high write strobe, one access per cycle.
- `ren_i`  in  1  active-high read strobe.
- `rdata_o`  out  32  registered read data.

## Operation
- Edge detect: `src_q` holds the previous `irq_src_i` sample. Rising edge on bit k (`irq_src_i[k] & ~src_q[k]`) sets `pending[k]`.
- PENDING (offset 0): read returns pending zero-extended to 32 bits. Write-1-to-clear. A set and a clear on the same bit in the same cycle leaves the bit set.
- ENABLE (offset 1): read/write, bits `[NUM_SRC-1:0]`; upper bits read 0.
- CLAIM (offset 2): read-only, returns `claim_id` (0 when idle). Writes are ignored.
- COMPLETE (offset 3): write-only, reads 0. A write whose `wdata_i[4:0]` equals `claim_id` ends service. Other values are ignored.
- Selection: `sel_id` is the lowest-index bit of `pending & enable`, plus 1. If no bit is set, `sel_id` is 0.
- State machine:
  - IDLE: `meip_o` = 0. Go to REQ when `sel_id != 0`.
  - REQ: `meip_o` = 1.
    - On `ack_i`: `claim_id <= sel_id`, clear `pending[sel_id-1]`, go to BUSY.
    - If `sel_id` becomes 0 without `ack_i` (source disabled or W1C), go to IDLE.
  - BUSY: `meip_o` = 0. On a matching COMPLETE write: `claim_id <= 0`, go to IDLE. New edges still set pending bits while BUSY.
- `ack_i` in IDLE or BUSY is ignored.
- If an edge on the source being claimed arrives in the same cycle as `ack_i`, that pending bit stays set (set wins). It is serviced after COMPLETE.
- Reset:
  - `pending`, `enable`, `src_q`, `claim_id` = 0; state = IDLE.
  - `meip_o` = 0, `rdata_o` = 0.
  - A source held high through reset registers one edge in the first cycle after reset.
- Reset asserted in any state, including REQ or BUSY, aborts the claim immediately with no further side effects.

## Timing
- Source edge at cycle N: `pending` set at N+1, state REQ and `meip_o` high at N+2.
- `ack_i` at cycle N: BUSY and `meip_o` low from N+1. `claim_id` readable by a read issued at N+1 or later.
- Read: `ren_i` at cycle N gives `rdata_o` valid at N+1. `rdata_o` holds its value otherwise.
- Write takes effect at the next rising edge.
- COMPLETE at cycle N: IDLE at N+1. If another enabled source is pending, REQ at N+2.
- `meip_o` is a registered output (state decode only), so the CSR unit's falling-edge sample sees a stable level.

## Configuration
- `IRQC_LEVEL_EN` defined:
  - Level-sensitive mode: `pending` equals registered `irq_src_i` each cycle; edge detect is removed.
  - W1C writes to PENDING are ignored; `ack_i` does not clear pending.
  - The peripheral must drop its request before the handler writes COMPLETE.
- `IRQC_LEVEL_EN` undefined: edge-triggered behaviour as described above.

## Test plan
- ENABLE=0x05, pulse `irq_src_i[2]` for 1 cycle:
  - `meip_o` rises 2 cycles later.
  - `ack_i` pulse, then CLAIM reads 3 and PENDING reads 0x00.
  - COMPLETE write 3 returns to IDLE with `meip_o` = 0.
- ENABLE=0xFF, pulse sources 5 and 1 in the same cycle, `ack_i`:
  - CLAIM reads 2.
  - COMPLETE 2 re-raises `meip_o` 2 cycles later.
  - Second `ack_i`: CLAIM reads 6.
- In REQ for source 0: write ENABLE=0 -> `meip_o` drops next cycle, PENDING still reads 0x01; a later `ack_i` is ignored and CLAIM reads 0.
- In BUSY with `claim_id`=4: COMPLETE write 7 -> stays BUSY; COMPLETE write 4 -> IDLE.
- Source 3 edge in the same cycle as `ack_i` claiming ID 4 -> PENDING bit 3 remains 1 and is serviced after COMPLETE 4.
- Assert `reset_i` in BUSY with `irq_src_i[0]` held high:
  - All outputs 0 during reset.
  - After release: PENDING reads 0x01; `meip_o` stays 0 because ENABLE is 0.
